// File: rtl/joypad_serializer_multi.sv
// NES-style multi-port joypad serializer: strobe latch, per-port falling-edge shift with
// 1-fill, autofire masking, port swap, saturating read counters and sticky over-read flags.
// Optional: define JOY_INPUT_SYNC_EN to pass strobe/ser_clk through 2-flop synchronisers.
module joypad_serializer_multi #(
  parameter int                   NUM_PORTS = 2,
  parameter int                   BTN_WIDTH = 8,
  parameter logic [BTN_WIDTH-1:0] AF_MASK   = 8'h03,
  parameter int                   AF_HALF   = 357950,
  parameter int                   CNT_W     = 5
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_PORTS*BTN_WIDTH-1:0] btn_in,
  input  logic [NUM_PORTS*BTN_WIDTH-1:0] af_req,
  input  logic                           swap,
  input  logic                           strobe,
  input  logic [NUM_PORTS-1:0]           ser_clk,
  output logic [NUM_PORTS-1:0]           ser_data,
  output logic [NUM_PORTS*CNT_W-1:0]     read_cnt,
  output logic [NUM_PORTS-1:0]           overread
);
  localparam int AFW = (AF_HALF > 2) ? $clog2(AF_HALF) : 1;

  logic                 w_strobe;
  logic [NUM_PORTS-1:0] w_ser_clk;

`ifdef JOY_INPUT_SYNC_EN
  logic [1:0]           r_strb_sync;
  logic [NUM_PORTS-1:0] r_sclk_s1, r_sclk_s2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_strb_sync <= '0;
      r_sclk_s1   <= '0;
      r_sclk_s2   <= '0;
    end else begin
      r_strb_sync <= {r_strb_sync[0], strobe};
      r_sclk_s1   <= ser_clk;
      r_sclk_s2   <= r_sclk_s1;
    end
  end

  assign w_strobe  = r_strb_sync[1];
  assign w_ser_clk = r_sclk_s2;
`else
  assign w_strobe  = strobe;
  assign w_ser_clk = ser_clk;
`endif

  // Shared autofire timer, free-running independent of strobe
  logic [AFW-1:0] r_af_cnt;
  logic           r_af_phase;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == AFW'(AF_HALF - 1)) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt   <= r_af_cnt + 1'b1;
    end
  end

  logic [NUM_PORTS-1:0][BTN_WIDTH-1:0] r_shift;
  logic [NUM_PORTS-1:0][CNT_W-1:0]     r_cnt;
  logic [NUM_PORTS-1:0]                r_ovr;
  logic [NUM_PORTS-1:0]                r_last;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam int SW = NUM_PORTS - 1 - p;

    logic [BTN_WIDTH-1:0] w_btn, w_af, w_latch;
    logic                 w_fall;

    assign w_btn   = swap ? btn_in[SW*BTN_WIDTH +: BTN_WIDTH] : btn_in[p*BTN_WIDTH +: BTN_WIDTH];
    assign w_af    = swap ? af_req[SW*BTN_WIDTH +: BTN_WIDTH] : af_req[p*BTN_WIDTH +: BTN_WIDTH];
    assign w_latch = w_btn | (w_af & AF_MASK & {BTN_WIDTH{r_af_phase}});
    assign w_fall  = r_last[p] & ~w_ser_clk[p];

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_shift[p] <= '1;
        r_cnt[p]   <= '0;
        r_ovr[p]   <= 1'b0;
        r_last[p]  <= 1'b0;
      end else begin
        r_last[p] <= w_ser_clk[p];
        if (w_strobe) begin
          r_shift[p] <= w_latch;
          r_cnt[p]   <= '0;
          r_ovr[p]   <= 1'b0;
        end else if (w_fall) begin
          r_shift[p] <= {1'b1, r_shift[p][BTN_WIDTH-1:1]};
          if (32'(r_cnt[p]) >= BTN_WIDTH) r_ovr[p] <= 1'b1;
          if (r_cnt[p] != '1)             r_cnt[p] <= r_cnt[p] + 1'b1;
        end
      end
    end

    assign ser_data[p]                 = r_shift[p][0];
    assign read_cnt[p*CNT_W +: CNT_W]  = r_cnt[p];
    assign overread[p]                 = r_ovr[p];
  end

endmodule

// File: tb/tb_joypad_serializer_multi.sv
// Directed bench for joypad_serializer_multi (2 ports x 8 bits, AF_HALF shortened to 4).
module tb_joypad_serializer_multi;
  localparam int NP = 2;
  localparam int BW = 8;
  localparam int CW = 5;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NP*BW-1:0] btn_in, af_req;
  logic             swap, strobe;
  logic [NP-1:0]    ser_clk, ser_data, overread;
  logic [NP*CW-1:0] read_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  joypad_serializer_multi #(
    .NUM_PORTS(NP), .BTN_WIDTH(BW), .AF_MASK(8'h03), .AF_HALF(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_in(btn_in), .af_req(af_req), .swap(swap),
    .strobe(strobe), .ser_clk(ser_clk), .ser_data(ser_data), .read_cnt(read_cnt),
    .overread(overread)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic load();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic fall(input logic [NP-1:0] m);
    ser_clk = m;
    tick();
    ser_clk = '0;
    tick();
  endtask

  initial begin
    logic [7:0] pat;
    resetn = 1'b0; btn_in = '0; af_req = '0; swap = 1'b0; strobe = 1'b0; ser_clk = '0;
    do_reset();
    chk("rst_data", 32'(ser_data), 32'h3);
    chk("rst_cnt",  32'(read_cnt), 32'h0);
    chk("rst_ovr",  32'(overread), 32'h0);

    // 1: A5 on port 0, bits read LSB first
    pat = 8'hA5;
    btn_in = {8'h00, pat};
    load();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_bit%0d", i), 32'(ser_data[0]), 32'(pat[i]));
      fall(2'b01);
    end
    chk("t1_fill",  32'(ser_data[0]), 32'h1);
    chk("t1_cnt",   32'(read_cnt[CW-1:0]), 32'd8);
    chk("t1_ovr",   32'(overread[0]), 32'h0);

    // 2: over-read
    fall(2'b01);
    chk("t2_ovr9",  32'(overread[0]), 32'h1);
    fall(2'b01);
    chk("t2_fill",  32'(ser_data[0]), 32'h1);
    chk("t2_ovr",   32'(overread[0]), 32'h1);
    chk("t2_cnt",   32'(read_cnt[CW-1:0]), 32'd10);
    chk("t2_p1cnt", 32'(read_cnt[2*CW-1:CW]), 32'd0);
    load();
    chk("t2_ovrclr", 32'(overread[0]), 32'h0);
    chk("t2_cntclr", 32'(read_cnt[CW-1:0]), 32'd0);

    // 3: swap
    swap = 1'b1;
    btn_in = {8'h80, 8'h01};
    load();
    chk("t3_d0", 32'(ser_data[0]), 32'h0);
    chk("t3_d1", 32'(ser_data[1]), 32'h1);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) swap = 1'b0;
      fall(2'b01);
    end
    chk("t3_d0_bit7", 32'(ser_data[0]), 32'h1);
    chk("t3_d1_hold", 32'(ser_data[1]), 32'h1);
    fall(2'b01);
    chk("t3_d0_fill", 32'(ser_data[0]), 32'h1);
    swap = 1'b0;

    // 4: autofire, strobe held high from the first cycle after reset
    btn_in = '0;
    af_req = {8'h00, 8'h01};
    do_reset();
    strobe = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t4_af%0d", k), 32'(ser_data[0]), 32'(((k - 1) / 4) % 2));
    end
    af_req = {8'h00, 8'h04};
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t4_nomask%0d", k), 32'(ser_data[0]), 32'h0);
    end
    strobe = 1'b0;
    af_req = '0;

    // 5: strobe priority, then simultaneous edges
    btn_in = {8'h01, 8'h02};
    strobe = 1'b1;
    ser_clk = 2'b01;
    tick();
    ser_clk = 2'b00;
    tick();
    strobe = 1'b0;
    tick();
    chk("t5_nocnt",  32'(read_cnt[CW-1:0]), 32'd0);
    chk("t5_noshft", 32'(ser_data[0]), 32'h0);
    fall(2'b11);
    chk("t5_cnt0", 32'(read_cnt[CW-1:0]), 32'd1);
    chk("t5_cnt1", 32'(read_cnt[2*CW-1:CW]), 32'd1);
    chk("t5_d",    32'(ser_data), 32'h1);

    // 6: reset mid-sequence
    btn_in = '0;
    load();
    for (int i = 0; i < 9; i++) fall(2'b10);
    for (int i = 0; i < 3; i++) fall(2'b01);
    chk("t6_pre_d0",  32'(ser_data[0]), 32'h0);
    chk("t6_pre_ovr", 32'(overread), 32'h2);
    resetn = 1'b0;
    tick();
    chk("t6_data", 32'(ser_data), 32'h3);
    chk("t6_cnt",  32'(read_cnt), 32'h0);
    chk("t6_ovr",  32'(overread), 32'h0);
    resetn = 1'b1;
    af_req = {8'h00, 8'h01};
    load();
    chk("t6_afphase", 32'(ser_data[0]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/joypad_serializer_multi.md
Name: joypad_serializer_multi

Overview:
- Parametrised successor to the two-port 8-bit joypad shift logic in the top level.
- Serves NUM_PORTS controller ports of BTN_WIDTH bits each, NES-style: parallel latch on strobe, shift on the falling edge of each port's serial clock, 1-fill after the last bit.
- Adds per-button autofire masking, a port-swap mode, saturating per-port read counters and sticky over-read flags.
- Sits between the controller/USB button aggregation and the core's joypad data inputs, in the clk domain.

Parameters:
- NUM_PORTS, 2, number of controller ports (1..4).
- BTN_WIDTH, 8, bits shifted per port per strobe (4..16).
- AF_MASK, 8'h03, button bits eligible for autofire; width BTN_WIDTH.
- AF_HALF, 357950, autofire half-period in clk cycles (about 30 Hz at 21.477 MHz); must be ≥ 2.
- CNT_W, 5, width of each per-port read counter.

Ports:
- clk  in  1  core clock.
- resetn  in  1  synchronous active-low reset.
- btn_in  in  NUM_PORTS*BTN_WIDTH  button state, 1 = pressed; port p occupies [p*BTN_WIDTH +: BTN_WIDTH].
- af_req  in  NUM_PORTS*BTN_WIDTH  autofire request per button, same packing.
- swap  in  1  1 = port p latches source port NUM_PORTS-1-p.
- strobe  in  1  latch/reload, level sensitive.
- ser_clk  in  NUM_PORTS  per-port serial clock from the core.
- ser_data  out  NUM_PORTS  bit 0 of each port's shift register.
- read_cnt  out  NUM_PORTS*CNT_W  falling edges counted since the last strobe, saturating.
- overread  out  NUM_PORTS  sticky; set when a shift occurs with read_cnt ≥ BTN_WIDTH.

Behaviour:
- Reset (resetn low at a clk edge):
  - shift registers all ones, so ser_data = all ones;
  - read_cnt = 0; overread = 0;
  - af_cnt = 0; af_phase = 0;
  - last_ser_clk = 0, so no edge is detected on the first cycle after reset.
- Autofire timer:
  - af_cnt counts 0..AF_HALF-1; af_phase toggles on wrap.
  - It is a single shared counter that runs regardless of strobe.
- Latch value for port p, with s = swap ? NUM_PORTS-1-p : p:
  - btn_in[s] | (af_req[s] & AF_MASK & {BTN_WIDTH{af_phase}}).
- While strobe = 1:
  - every clk edge reloads all shift registers with the current latch value;
  - read_cnt = 0; overread cleared;
  - serial-clock edges are ignored, so strobe has priority over simultaneous edges.
- Falling edge on port p (ser_clk[p] = 0 and last_ser_clk[p] = 1) with strobe = 0:
  - shift register <= {1'b1, shift[BTN_WIDTH-1:1]};
  - if read_cnt[p] ≥ BTN_WIDTH, set overread[p];
  - read_cnt[p] increments, saturating at 2^CNT_W-1.
- last_ser_clk is updated every cycle, including while strobe is high.
- Latency: ser_data updates on the same clk edge that samples the falling edge, so it is visible one cycle after ser_clk is first seen low.
- Ports are fully independent. Simultaneous edges on several ports each shift in the same cycle.
- swap, btn_in and af_req changes take effect only at the next strobe load. Shifting contents are never disturbed.
- After BTN_WIDTH shifts, ser_data stays 1 (the fill value).
- Reset asserted mid-sequence returns every register to its reset value on that edge.
- All registers update only on posedge clk. There is no combinational path from inputs to outputs except ser_data = shift[0].

Optional Feature:
- JOY_INPUT_SYNC_EN defined:
  - strobe and ser_clk each pass through a 2-flop synchroniser (reset value 0) before use;
  - strobe load and edge detect are delayed by 2 cycles, so ser_data responds 3 cycles after the input edge.
- Undefined: inputs are used directly, with the 1-cycle response above.

Test Plan:
1. Reset, then strobe 1 cycle with btn_in port0 = 8'hA5, af_req = 0 → ser_data[0] = 1 after load. Eight falling edges read 1,0,1,0,0,1,0,1. read_cnt[0] = 8, overread[0] = 0.
2. After test 1, a 9th and 10th falling edge → ser_data[0] = 1, overread[0] = 1, read_cnt[0] = 10. Next strobe → overread[0] = 0, read_cnt[0] = 0.
3. swap = 1, port0 = 8'h01, port1 = 8'h80, strobe → ser_data[0] = 0 and ser_data[1] = 1 after load. Toggling swap mid-read does not change the remaining bits.
4. AF_HALF = 4 (test override), af_req port0 = 8'h01, btn_in = 0, strobe each cycle for 16 cycles → ser_data[0] = 0,0,0,0,1,1,1,1 repeating. af_req = 8'h04 (outside AF_MASK) → always 0.
5. strobe held high while ser_clk[0] falls → no shift, read_cnt[0] = 0. Both ports falling in the same cycle → both shift, both read_cnt = 1.
6. Assert resetn = 0 after 3 shifts → next cycle ser_data = all ones, read_cnt = 0, overread = 0, af_phase = 0.
